// File: rtl/hwclk_timer_mmio_pkg.sv
// Shared definitions for the MMIO hardware timer.
//  - Byte offsets of the register window.
//  - ctrl_t: layout of the CTRL register ({reload, run}, run in bit 0).
//  - STATUS bit positions: match flags at [NUM_CH-1:0], overflow at [NUM_CH].
`timescale 1ns/1ps
package t03_timer_pkg;

    localparam logic [7:0] OFS_CTRL     = 8'h00;
    localparam logic [7:0] OFS_PRESC    = 8'h04;
    localparam logic [7:0] OFS_COUNT    = 8'h08;
    localparam logic [7:0] OFS_STATUS   = 8'h0C;
    localparam logic [7:0] OFS_IRQ_EN   = 8'h10;
    localparam logic [7:0] OFS_CMP_BASE = 8'h20;

    typedef struct packed {
        logic reload;  // bit 1: counter returns to 0 on a CH0 match
        logic run;     // bit 0: counting enabled
    } ctrl_t;

    localparam int STATUS_MATCH_LSB = 0;

    // Overflow flag sits directly above the per-channel match flags.
    function automatic int status_ovf_bit(input int num_ch);
        return num_ch;
    endfunction

endpackage

// File: rtl/hwclk_timer_mmio_if.sv
// CPU-side MMIO bus of the timer.
//  addr  : byte address (bits [1:0] ignored)
//  wdata : write data
//  wen   : write request pulse
//  ren   : read request pulse
//  rdata : read data, valid with ack and held afterwards
//  ack   : one-cycle completion pulse
//  irq   : level interrupt from the timer
`timescale 1ns/1ps
interface hwclk_timer_mmio_if #(
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              wen;
    logic              ren;
    logic [31:0]       rdata;
    logic              ack;
    logic              irq;

    modport master (
        output addr, wdata, wen, ren,
        input  rdata, ack, irq
    );

    modport slave (
        input  addr, wdata, wen, ren,
        output rdata, ack, irq
    );
endinterface

// File: rtl/hwclk_timer_mmio_prescaler.sv
// Prescaler phase counter for the timer.
//  clk   : system clock
//  rst   : asynchronous reset, active-high
//  run   : advance phase; when low the phase is frozen
//  presc : tick every presc+1 clocks
//  clr   : restart the phase at 0 (COUNT write)
//  tick  : combinational, high in the cycle the counter should advance
`timescale 1ns/1ps
module hwclk_prescaler #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic [PRESCALE_W-1:0] presc,
    input  logic                  clr,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] phase;

    // >= rather than == so that lowering PRESC below the current phase
    // ticks on the next running cycle instead of wrapping the whole phase range.
    assign tick = run & (phase >= presc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       phase <= '0;
        else if (clr)  phase <= '0;
        else if (tick) phase <= '0;
        else if (run)  phase <= phase + 1'b1;
    end

endmodule

// File: rtl/hwclk_timer_mmio.sv
// Memory-mapped hardware timer: free-running prescaled counter, NUM_CH compare
// channels, sticky match/overflow flags and a registered level interrupt.
//  clk : system clock
//  rst : asynchronous reset, active-high
//  bus : MMIO slave port (addr, wdata, wen, ren -> rdata, ack, irq)
// Every request sampled in cycle N is acked in N+1; reads return the register
// value as of cycle N. wen+ren together is treated as a write.
`timescale 1ns/1ps
module hwclk_timer_mmio
    import t03_timer_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int WIDTH      = 32,
    parameter int PRESCALE_W = 16,
    parameter int ADDR_W     = 6
) (
    input  logic              clk,
    input  logic              rst,
    hwclk_timer_mmio_if.slave bus
);

    localparam int SW  = NUM_CH + 1;
    localparam int OVF = status_ovf_bit(NUM_CH);

    ctrl_t                        ctrl;
    logic [PRESCALE_W-1:0]        presc;
    logic [WIDTH-1:0]             count;
    logic [SW-1:0]                status;
    logic [SW-1:0]                irq_en;
    logic [NUM_CH-1:0][WIDTH-1:0] cmp;

    logic [31:0] rdata_q;
    logic        ack_q;
    logic        irq_q;

    // ---------------- decode ----------------
    logic [31:0]       a32;
    logic              wr, rd;
    logic              sel_ctrl, sel_presc, sel_count, sel_status, sel_irq_en;
    logic [NUM_CH-1:0] sel_cmp;

    assign a32        = 32'(bus.addr) & ~32'h3;
    assign wr         = bus.wen;
    assign rd         = bus.ren & ~bus.wen;
    assign sel_ctrl   = (a32 == 32'(OFS_CTRL));
    assign sel_presc  = (a32 == 32'(OFS_PRESC));
    assign sel_count  = (a32 == 32'(OFS_COUNT));
    assign sel_status = (a32 == 32'(OFS_STATUS));
    assign sel_irq_en = (a32 == 32'(OFS_IRQ_EN));

    for (genvar i = 0; i < NUM_CH; i++) begin : g_sel
        assign sel_cmp[i] = (a32 == 32'(OFS_CMP_BASE) + 32'(4 * i));
    end

    logic unused_wdata;
    assign unused_wdata = ^bus.wdata;

    // ---------------- tick ----------------
    logic count_wr, tick, adv;

    assign count_wr = wr & sel_count;

    hwclk_prescaler #(.PRESCALE_W(PRESCALE_W)) u_presc (
        .clk   (clk),
        .rst   (rst),
        .run   (ctrl.run),
        .presc (presc),
        .clr   (count_wr),
        .tick  (tick)
    );

    // A COUNT write wins over a tick in the same cycle and suppresses its flags.
    assign adv = tick & ~count_wr;

    // ---------------- compare / flags ----------------
    logic [WIDTH-1:0]  cnt_inc;
    logic [NUM_CH-1:0] match;
    logic [SW-1:0]     set_mask, clr_mask;

    assign cnt_inc = count + 1'b1;

    // Compares against the CMP value currently held, so a CMP write landing
    // in the same cycle only affects later ticks.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign match[i]                  = (cnt_inc == cmp[i]);
        assign set_mask[STATUS_MATCH_LSB + i] = adv & match[i];
    end
    assign set_mask[OVF] = adv & (&count);

    assign clr_mask = (wr & sel_status) ? bus.wdata[SW-1:0] : '0;

    // ---------------- registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl   <= '0;
            presc  <= '0;
            irq_en <= '0;
            cmp    <= '1;
        end else if (wr) begin
            if (sel_ctrl)   ctrl   <= ctrl_t'(bus.wdata[1:0]);
            if (sel_presc)  presc  <= bus.wdata[PRESCALE_W-1:0];
            if (sel_irq_en) irq_en <= bus.wdata[SW-1:0];
            for (int i = 0; i < NUM_CH; i++)
                if (sel_cmp[i]) cmp[i] <= bus.wdata[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           count <= '0;
        else if (count_wr) count <= bus.wdata[WIDTH-1:0];
        else if (adv)      count <= (ctrl.reload && match[0]) ? '0 : cnt_inc;
    end

    // Set takes priority over a same-cycle write-1-to-clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) status <= '0;
        else     status <= (status & ~clr_mask) | set_mask;
    end

    // ---------------- read mux / handshake ----------------
    logic [31:0] rd_val;

    always_comb begin
        rd_val = '0;
        if (sel_ctrl)   rd_val = 32'(ctrl);
        if (sel_presc)  rd_val = 32'(presc);
        if (sel_count)  rd_val = 32'(count);
        if (sel_status) rd_val = 32'(status);
        if (sel_irq_en) rd_val = 32'(irq_en);
        for (int i = 0; i < NUM_CH; i++)
            if (sel_cmp[i]) rd_val = 32'(cmp[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            ack_q <= bus.wen | bus.ren;
            if (rd) rdata_q <= rd_val;
            irq_q <= |(status & irq_en);
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ack   = ack_q;
    assign bus.irq   = irq_q;

endmodule

// File: tb/tb_hwclk_timer_mmio.sv
// Self-checking bench for hwclk_timer_mmio (NUM_CH=2, WIDTH=32).
// Table of reset reads and write/readback vectors, randomized run intervals
// checked against an arithmetic model of the counter, and hand sequences for
// overflow/irq, reload, COUNT-write-vs-tick and wen+ren collisions.
`timescale 1ns/1ps
module tb_hwclk_timer_mmio;

    localparam logic [5:0] A_CTRL   = 6'h00;
    localparam logic [5:0] A_PRESC  = 6'h04;
    localparam logic [5:0] A_COUNT  = 6'h08;
    localparam logic [5:0] A_STATUS = 6'h0C;
    localparam logic [5:0] A_IRQEN  = 6'h10;
    localparam logic [5:0] A_CMP0   = 6'h20;
    localparam logic [5:0] A_CMP1   = 6'h24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hwclk_timer_mmio_if #(.ADDR_W(6)) bus ();

    hwclk_timer_mmio #(
        .NUM_CH(2), .WIDTH(32), .PRESCALE_W(16), .ADDR_W(6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0]  a;
        bit          do_wr;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Tasks start and end on a falling edge; each request takes one cycle.
    task automatic bus_wr(input logic [5:0] a, input logic [31:0] d);
        bus.addr = a; bus.wdata = d; bus.wen = 1'b1; bus.ren = 1'b0;
        @(negedge clk);
        bus.wen = 1'b0;
        chk("wr_ack", 32'(bus.ack), 32'd1);
    endtask

    task automatic bus_rd(input logic [5:0] a, output logic [31:0] d);
        bus.addr = a; bus.ren = 1'b1; bus.wen = 1'b0;
        @(negedge clk);
        bus.ren = 1'b0;
        chk("rd_ack", 32'(bus.ack), 32'd1);
        d = bus.rdata;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vq[$];
        vec_t        v;
        logic [31:0] rd, held;
        logic [31:0] start, c0, c1, cnt_exp, st_exp, off;
        int          p, w, k, ie;

        bus.addr = '0; bus.wdata = '0; bus.wen = 1'b0; bus.ren = 1'b0;

        // reset reads: CMP slots all-ones, everything else zero
        for (int i = 0; i < 16; i++) begin
            v.a = 6'(4 * i); v.do_wr = 1'b0; v.wd = '0;
            v.exp = (i == 8 || i == 9) ? 32'hFFFF_FFFF : 32'h0;
            vq.push_back(v);
        end
        // write then read back (counter stopped throughout)
        vq.push_back('{A_CTRL,   1'b1, 32'hFFFF_FFFE, 32'h0000_0002});
        vq.push_back('{A_PRESC,  1'b1, 32'h0001_2345, 32'h0000_2345});
        vq.push_back('{A_COUNT,  1'b1, 32'hCAFE_BABE, 32'hCAFE_BABE});
        vq.push_back('{A_IRQEN,  1'b1, 32'hFFFF_FFFF, 32'h0000_0007});
        vq.push_back('{A_STATUS, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000});
        vq.push_back('{A_CMP0,   1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF});
        vq.push_back('{A_CMP1,   1'b1, 32'h0000_0001, 32'h0000_0001});
        vq.push_back('{6'h14,    1'b1, 32'h0000_5555, 32'h0000_0000});
        vq.push_back('{6'h28,    1'b1, 32'h0000_1234, 32'h0000_0000});
        vq.push_back('{6'h0B,    1'b0, 32'h0,         32'hCAFE_BABE});

        idle(3);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ack",   32'(bus.ack),   32'd0);
        chk("rst_irq",   32'(bus.irq),   32'd0);
        chk("rst_rdata", bus.rdata,      32'd0);

        foreach (vq[i]) begin
            if (vq[i].do_wr) bus_wr(vq[i].a, vq[i].wd);
            bus_rd(vq[i].a, rd);
            chk($sformatf("vec%0d_a%02h", i, vq[i].a), rd, vq[i].exp);
        end
        idle(1);
        chk("ack_drops", 32'(bus.ack), 32'd0);

        // randomized run intervals vs. arithmetic model
        for (int t = 0; t < 24; t++) begin
            p     = $urandom_range(0, 3);
            w     = $urandom_range(0, 40);
            ie    = $urandom_range(0, 7);
            start = $urandom_range(0, 1) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 20))) : 32'($urandom);
            c0    = start + 32'($urandom_range(1, 45));
            c1    = start + 32'($urandom_range(1, 45));
            bus_wr(A_CTRL, 32'h0);
            bus_wr(A_PRESC, 32'(p));
            bus_wr(A_CMP0, c0);
            bus_wr(A_CMP1, c1);
            bus_wr(A_IRQEN, 32'(ie));
            bus_wr(A_COUNT, start);
            bus_wr(A_STATUS, 32'h7);
            bus_wr(A_CTRL, 32'h1);
            idle(w);
            bus_wr(A_CTRL, 32'h0);
            // counter ran for w+1 cycles; one tick per p+1 of them
            k       = (w + 1) / (p + 1);
            cnt_exp = start + 32'(k);
            st_exp  = '0;
            off = c0 - start;   if (off >= 1 && off <= 32'(k)) st_exp[0] = 1'b1;
            off = c1 - start;   if (off >= 1 && off <= 32'(k)) st_exp[1] = 1'b1;
            off = 32'h0 - start; if (off >= 1 && off <= 32'(k)) st_exp[2] = 1'b1;
            bus_rd(A_COUNT, rd);
            chk($sformatf("rnd%0d_count", t), rd, cnt_exp);
            bus_rd(A_STATUS, rd);
            chk($sformatf("rnd%0d_status", t), rd, st_exp);
            chk($sformatf("rnd%0d_irq", t), 32'(bus.irq), 32'(|(st_exp[2:0] & 3'(ie))));
        end

        // overflow raises STATUS[2] two ticks after run, irq one cycle later
        bus_wr(A_CTRL, 32'h0);
        bus_wr(A_STATUS, 32'h7);
        bus_wr(A_IRQEN, 32'h4);
        bus_wr(A_PRESC, 32'h0);
        bus_wr(A_COUNT, 32'hFFFF_FFFE);
        bus_wr(A_CTRL, 32'h1);
        chk("ovf_irq_t0", 32'(bus.irq), 32'd0);
        idle(1);
        chk("ovf_irq_t1", 32'(bus.irq), 32'd0);
        idle(1);
        chk("ovf_irq_t2", 32'(bus.irq), 32'd0);
        idle(1);
        chk("ovf_irq_t3", 32'(bus.irq), 32'd1);
        bus_wr(A_CTRL, 32'h0);
        bus_rd(A_STATUS, rd);
        chk("ovf_status2", rd & 32'h4, 32'h4);
        bus_wr(A_STATUS, 32'h4);
        chk("ovf_irq_w1c_lag", 32'(bus.irq), 32'd1);
        idle(1);
        chk("ovf_irq_cleared", 32'(bus.irq), 32'd0);

        // reload on CH0 match: count runs 0..4,0..; 13 ticks -> 3
        bus_wr(A_PRESC, 32'h0);
        bus_wr(A_CMP0, 32'd5);
        bus_wr(A_CMP1, 32'd3);
        bus_wr(A_COUNT, 32'd0);
        bus_wr(A_STATUS, 32'h7);
        bus_wr(A_CTRL, 32'h3);
        idle(12);
        bus_wr(A_CTRL, 32'h0);
        bus_rd(A_COUNT, rd);
        chk("reload_count", rd, 32'd3);
        bus_rd(A_STATUS, rd);
        chk("reload_status", rd, 32'h3);

        // COUNT write lands on the tick that would match CMP0=101
        bus_wr(A_PRESC, 32'h1);
        bus_wr(A_CMP0, 32'd101);
        bus_wr(A_CMP1, 32'hFFFF_FFFF);
        bus_wr(A_COUNT, 32'd100);
        bus_wr(A_STATUS, 32'h7);
        bus_wr(A_CTRL, 32'h1);
        idle(1);
        bus_wr(A_COUNT, 32'd100);
        bus_wr(A_CTRL, 32'h0);
        bus_rd(A_COUNT, rd);
        chk("cwr_tick_count", rd, 32'd100);
        bus_rd(A_STATUS, rd);
        chk("cwr_tick_status", rd, 32'h0);

        // wen+ren together is a write and leaves rdata alone
        bus_rd(A_PRESC, held);
        chk("coll_pre", held, 32'h1);
        bus.addr = A_IRQEN; bus.wdata = 32'h1; bus.wen = 1'b1; bus.ren = 1'b1;
        @(negedge clk);
        bus.wen = 1'b0; bus.ren = 1'b0;
        chk("coll_ack", 32'(bus.ack), 32'd1);
        chk("coll_rdata_held", bus.rdata, held);
        bus_rd(A_IRQEN, rd);
        chk("coll_written", rd, 32'h1);
        bus_rd(6'h3C, rd);
        chk("unmapped_3c", rd, 32'h0);

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
